// File: rtl/arc4_pkg.sv
// ==========================================================================
// arc4_pkg : shared types, sizes and key-byte helper for the ARC4 decryptor
// Revision : 1.0
// ==========================================================================
`default_nettype none

package arc4_pkg;

  localparam int S_SIZE    = 256;
  localparam int KEY_BYTES = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NOKEY = 3'd1,
    INIT  = 3'd2,
    KSA   = 3'd3,
    RDLEN = 3'd4,
    PRGA  = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Micro-steps shared by KSA (first four) and PRGA (all six).
  typedef enum logic [2:0] {
    SUB_RD_I  = 3'd0,
    SUB_RD_J  = 3'd1,
    SUB_WR_I  = 3'd2,
    SUB_WR_J  = 3'd3,
    SUB_RD_PAD = 3'd4,
    SUB_OUT   = 3'd5
  } sub_t;

  // Key byte 0 is the most significant byte of the key word.
  function automatic logic [7:0] key_byte(input logic [8*KEY_BYTES-1:0] key,
                                          input logic [1:0] idx);
    return key[8*(KEY_BYTES-1-int'(idx)) +: 8];
  endfunction

endpackage

`default_nettype wire

// File: rtl/arc4_pt_decrypt_s_mem.sv
// ==========================================================================
// s_mem : 256x8 single-port synchronous RAM, 1-cycle read latency
// Revision : 1.0
// ==========================================================================
`default_nettype none

module s_mem
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] addr,
  input  logic [7:0] wrdata,
  input  logic       wren,
  output logic [7:0] rddata
);

  logic [7:0] mem [0:S_SIZE-1];
  logic [7:0] rddata_q;

  always_ff @(posedge clk) begin
    if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata_q <= mem[addr];
  end

  assign rddata = rddata_q;

endmodule

`default_nettype wire

// File: rtl/arc4_pt_decrypt.sv
// ==========================================================================
// arc4_pt_decrypt : re-runs ARC4 with a recovered key and writes the
//                   length-prefixed plaintext into pt_mem
// Revision : 1.0
// ==========================================================================
`default_nettype none

module arc4_pt_decrypt
  import arc4_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic                   key_valid,
  output logic [7:0]             ct_addr,
  input  logic [7:0]             ct_rddata,
  output logic [7:0]             pt_addr,
  output logic [7:0]             pt_wrdata,
  output logic                   pt_wren
);

  state_t state_q, state_d;
  sub_t   sub_q, sub_d;

  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [7:0] i_q, i_d, j_q, j_d, k_q, k_d, len_q, len_d;
  logic [7:0] si_q, si_d, sj_q, sj_d;
  logic [1:0] kidx_q, kidx_d;
  logic [7:0] ct_addr_q, ct_addr_d, pt_addr_q, pt_addr_d, pt_wrdata_q, pt_wrdata_d;
  logic       pt_wren_q, pt_wren_d;

  logic [7:0] s_addr, s_wrdata, s_rddata, j_new;
  logic       s_wren;

  s_mem u_s_mem (
    .clk    (clk),
    .addr   (s_addr),
    .wrdata (s_wrdata),
    .wren   (s_wren),
    .rddata (s_rddata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sub_q       <= SUB_RD_I;
      key_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      len_q       <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      kidx_q      <= '0;
      ct_addr_q   <= '0;
      pt_addr_q   <= '0;
      pt_wrdata_q <= '0;
      pt_wren_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sub_q       <= sub_d;
      key_q       <= key_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      len_q       <= len_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      kidx_q      <= kidx_d;
      ct_addr_q   <= ct_addr_d;
      pt_addr_q   <= pt_addr_d;
      pt_wrdata_q <= pt_wrdata_d;
      pt_wren_q   <= pt_wren_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sub_d       = sub_q;
    key_d       = key_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    len_d       = len_q;
    si_d        = si_q;
    sj_d        = sj_q;
    kidx_d      = kidx_q;
    ct_addr_d   = ct_addr_q;
    pt_addr_d   = pt_addr_q;
    pt_wrdata_d = pt_wrdata_q;
    pt_wren_d   = 1'b0;
    s_addr      = i_q;
    s_wrdata    = '0;
    s_wren      = 1'b0;
    j_new       = '0;

    unique case (state_q)
      IDLE: begin
        if (en) begin
          key_d     = key;
          ct_addr_d = '0;
          i_d       = '0;
          j_d       = '0;
          kidx_d    = '0;
          sub_d     = SUB_RD_I;
          state_d   = key_valid ? INIT : NOKEY;
        end
      end

      NOKEY: begin
        pt_wren_d   = 1'b1;
        pt_addr_d   = '0;
        pt_wrdata_d = '0;
        state_d     = DONE;
      end

      INIT: begin
        s_wren   = 1'b1;
        s_addr   = i_q;
        s_wrdata = i_q;
        i_d      = i_q + 8'd1;
        if (i_q == 8'hFF) begin
          state_d = KSA;
        end
      end

      KSA: begin
        unique case (sub_q)
          SUB_RD_I: begin
            s_addr = i_q;
            sub_d  = SUB_RD_J;
          end
          SUB_RD_J: begin
            j_new  = j_q + s_rddata + key_byte(key_q, kidx_q);
            si_d   = s_rddata;
            j_d    = j_new;
            s_addr = j_new;
            sub_d  = SUB_WR_I;
          end
          SUB_WR_I: begin
            s_wren   = 1'b1;
            s_addr   = i_q;
            s_wrdata = s_rddata;
            sub_d    = SUB_WR_J;
          end
          default: begin
            // Writing S[j] last keeps the i==j case a no-op.
            s_wren   = 1'b1;
            s_addr   = j_q;
            s_wrdata = si_q;
            i_d      = i_q + 8'd1;
            kidx_d   = (kidx_q == 2'd2) ? 2'd0 : kidx_q + 2'd1;
            sub_d    = SUB_RD_I;
            if (i_q == 8'hFF) begin
              j_d     = '0;
              state_d = RDLEN;
            end
          end
        endcase
      end

      RDLEN: begin
        // ct_addr has sat at 0 since acceptance, so ct_rddata already holds ct[0].
        len_d       = ct_rddata;
        pt_wren_d   = 1'b1;
        pt_addr_d   = '0;
        pt_wrdata_d = ct_rddata;
        if (ct_rddata == 8'd0) begin
          state_d = DONE;
        end else begin
          k_d       = 8'd1;
          ct_addr_d = 8'd1;
          i_d       = '0;
          j_d       = '0;
          sub_d     = SUB_RD_I;
          state_d   = PRGA;
        end
      end

      PRGA: begin
        unique case (sub_q)
          SUB_RD_I: begin
            i_d    = i_q + 8'd1;
            s_addr = i_q + 8'd1;
            sub_d  = SUB_RD_J;
          end
          SUB_RD_J: begin
            j_new  = j_q + s_rddata;
            si_d   = s_rddata;
            j_d    = j_new;
            s_addr = j_new;
            sub_d  = SUB_WR_I;
          end
          SUB_WR_I: begin
            s_wren   = 1'b1;
            s_addr   = i_q;
            s_wrdata = s_rddata;
            sj_d     = s_rddata;
            sub_d    = SUB_WR_J;
          end
          SUB_WR_J: begin
            s_wren   = 1'b1;
            s_addr   = j_q;
            s_wrdata = si_q;
            sub_d    = SUB_RD_PAD;
          end
          SUB_RD_PAD: begin
            s_addr = si_q + sj_q;
            sub_d  = SUB_OUT;
          end
          default: begin
            pt_wren_d   = 1'b1;
            pt_addr_d   = k_q;
            pt_wrdata_d = ct_rddata ^ s_rddata;
            sub_d       = SUB_RD_I;
            if (k_q == len_q) begin
              state_d = DONE;
            end else begin
              k_d       = k_q + 8'd1;
              ct_addr_d = k_q + 8'd1;
            end
          end
        endcase
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign rdy       = (state_q == IDLE);
  assign ct_addr   = ct_addr_q;
  assign pt_addr   = pt_addr_q;
  assign pt_wrdata = pt_wrdata_q;
  assign pt_wren   = pt_wren_q;

endmodule

`default_nettype wire

// File: tb/tb_arc4_pt_decrypt.sv
// ==========================================================================
// tb_arc4_pt_decrypt : directed self-checking bench for arc4_pt_decrypt
// Revision : 1.0
// ==========================================================================
`default_nettype none

module tb_arc4_pt_decrypt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        rdy;
  logic [23:0] key = '0;
  logic        key_valid = 1'b0;
  logic [7:0]  ct_addr;
  logic [7:0]  ct_rddata = '0;
  logic [7:0]  pt_addr;
  logic [7:0]  pt_wrdata;
  logic        pt_wren;

  arc4_pt_decrypt dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .rdy       (rdy),
    .key       (key),
    .key_valid (key_valid),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  always #5 clk = ~clk;

  logic [7:0] ct_mem [256];
  logic [7:0] exp_pt [256];
  logic [7:0] log_addr [2048];
  logic [7:0] log_data [2048];
  int         wr_cnt = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  int         max_ct;

  always @(posedge clk) begin
    ct_rddata <= ct_mem[ct_addr];
    if (pt_wren && wr_cnt < 2048) begin
      log_addr[wr_cnt] <= pt_addr;
      log_data[wr_cnt] <= pt_wrdata;
      wr_cnt           <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Straightforward software ARC4 over ct_mem, filling exp_pt[0..L].
  task automatic arc4_model(input logic [23:0] k);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] i, j, t;
    int len;
    kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
    for (int n = 0; n < 256; n++) s[n] = n[7:0];
    j = 0;
    for (int n = 0; n < 256; n++) begin
      j = j + s[n] + kb[n % 3];
      t = s[n]; s[n] = s[j]; s[j] = t;
    end
    len = int'(ct_mem[0]);
    exp_pt[0] = ct_mem[0];
    i = 0; j = 0;
    for (int n = 1; n <= len; n++) begin
      i = i + 8'd1;
      j = j + s[i];
      t = s[i]; s[i] = s[j]; s[j] = t;
      t = s[i] + s[j];
      exp_pt[n] = ct_mem[n] ^ s[t];
    end
  endtask

  // Called at a negedge while rdy is expected high.
  task automatic start(input logic [23:0] k, input logic kv);
    check("rdy_before_start", {31'd0, rdy}, 32'd1);
    en = 1'b1; key = k; key_valid = kv;
    @(negedge clk);
    en = 1'b0; key = 24'hA5A5A5; key_valid = ~kv;
    check("rdy_low_after_accept", {31'd0, rdy}, 32'd0);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    max_ct = int'(ct_addr);
    while (rdy !== 1'b1 && cyc <= budget) begin
      @(negedge clk);
      cyc++;
      if (int'(ct_addr) > max_ct) max_ct = int'(ct_addr);
    end
    check("latency_within_bound", {31'd0, cyc <= budget}, 32'd1);
  endtask

  task automatic check_run(input string name, input int base, input int n);
    check($sformatf("%s_write_count", name), wr_cnt - base, n);
    for (int x = 0; x < n && base + x < 2048; x++) begin
      check($sformatf("%s_addr[%0d]", name, x), {24'd0, log_addr[base + x]}, x);
      check($sformatf("%s_pt[%0d]", name, x), {24'd0, log_data[base + x]}, {24'd0, exp_pt[x]});
    end
  endtask

  task automatic load_known;
    logic [7:0] c [10];
    logic [7:0] p [10];
    c = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    p = '{8'h09, 8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    for (int x = 0; x < 10; x++) begin
      ct_mem[x] = c[x];
      exp_pt[x] = p[x];
    end
  endtask

  initial begin
    int base, cyc, hold;
    for (int x = 0; x < 256; x++) ct_mem[x] = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_rdy", {31'd0, rdy}, 32'd1);
    check("reset_pt_wren", {31'd0, pt_wren}, 32'd0);
    check("reset_pt_addr", {24'd0, pt_addr}, 32'd0);
    check("reset_pt_wrdata", {24'd0, pt_wrdata}, 32'd0);
    check("reset_ct_addr", {24'd0, ct_addr}, 32'd0);

    // Known "Key" / "Plaintext" vector
    load_known();
    base = wr_cnt;
    start(24'h4B6579, 1'b1);
    wait_done(256 + 1536 + 9 * 8 + 8, cyc);
    check_run("known", base, 10);

    // No key found
    @(negedge clk);
    base = wr_cnt;
    start(24'h4B6579, 1'b0);
    wait_done(3, cyc);
    exp_pt[0] = 8'h00;
    check_run("nokey", base, 1);

    // Zero-length ciphertext
    @(negedge clk);
    ct_mem[0] = 8'h00;
    base = wr_cnt;
    start(24'h000018, 1'b1);
    wait_done(256 + 1536 + 8, cyc);
    check("len0_after_ksa", {31'd0, cyc > 512}, 32'd1);
    check("len0_ct_addr_max", max_ct, 0);
    exp_pt[0] = 8'h00;
    check_run("len0", base, 1);

    // Full 255-byte message, random ciphertext
    @(negedge clk);
    ct_mem[0] = 8'hFF;
    for (int x = 1; x < 256; x++) ct_mem[x] = 8'($urandom_range(0, 255));
    arc4_model(24'h000018);
    base = wr_cnt;
    start(24'h000018, 1'b1);
    wait_done(256 + 1536 + 255 * 8 + 8, cyc);
    check_run("len255", base, 256);

    // Busy en ignored, then reset mid-PRGA
    @(negedge clk);
    load_known();
    base = wr_cnt;
    start(24'h4B6579, 1'b1);
    repeat (5) @(negedge clk);
    en = 1'b1; key = 24'h000000; key_valid = 1'b0;
    @(negedge clk);
    en = 1'b0;
    cyc = 0;
    while (wr_cnt - base < 3 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check("reached_prga", {31'd0, cyc < 3000}, 32'd1);
    check("busy_en_ignored_addr", {24'd0, log_addr[base]}, 32'd0);
    check("busy_en_ignored_len", {24'd0, log_data[base]}, 32'd9);
    rst = 1'b1;
    @(negedge clk);
    check("abort_rdy", {31'd0, rdy}, 32'd1);
    check("abort_pt_wren", {31'd0, pt_wren}, 32'd0);
    rst = 1'b0;
    hold = wr_cnt;
    repeat (20) @(negedge clk);
    check("abort_no_writes", wr_cnt, hold);
    base = wr_cnt;
    start(24'h4B6579, 1'b1);
    wait_done(256 + 1536 + 9 * 8 + 8, cyc);
    check_run("rerun", base, 10);

    // Back-to-back: accept on the very first rdy cycle
    for (int x = 0; x < 17; x++) ct_mem[x] = 8'($urandom_range(0, 255));
    ct_mem[0] = 8'd16;
    arc4_model(24'h000018);
    base = wr_cnt;
    start(24'h000018, 1'b1);
    wait_done(256 + 1536 + 16 * 8 + 8, cyc);
    check_run("b2b", base, 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arc4_pt_decrypt.md
Name: arc4_pt_decrypt

Overview:
Downstream stage of doublecrack. It consumes the 24-bit key and key_valid that doublecrack produces and the same length-prefixed ciphertext memory. It re-runs full ARC4 (S init, KSA, PRGA) with that key and writes the length-prefixed plaintext into pt_mem. Its en/rdy microprotocol is identical to crack/doublecrack, so the top level chains them directly.

Parameters:
KEY_BYTES, 3, key length in bytes; key byte n is key[8*(KEY_BYTES-1-n) +: 8], MSB byte first.
S_SIZE, 256, ARC4 state size; fixed, not to be overridden.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  start request; honoured only on a cycle with rdy=1.
rdy  out  1  high when idle and able to accept en.
key  in  24  candidate key from doublecrack; sampled on the accepting cycle.
key_valid  in  1  sampled with key; 0 means no key was found.
ct_addr  out  8  ciphertext memory address; memory has 1-cycle read latency.
ct_rddata  in  8  ciphertext read data.
pt_addr  out  8  plaintext memory address.
pt_wrdata  out  8  plaintext write data.
pt_wren  out  1  plaintext write strobe; one byte written per cycle it is high.

Behaviour:
- Reset, sampled at the clock edge: state=IDLE, rdy=1, pt_wren=0, pt_addr=0, pt_wrdata=0, ct_addr=0. Takes effect on the cycle after rst is sampled high. Reset overrides en. pt_mem and S contents are not cleared.
- Handshake:
  - en with rdy=1 latches key and key_valid. rdy is 0 from the next cycle until completion.
  - en while rdy=0 is ignored. en must not be treated as level-held.
- On completion, rdy returns to 1 in the cycle after the last pt write. A new en is accepted in that same rdy cycle.
- States: IDLE -> (key_valid ? INIT : NOKEY); INIT -> KSA -> RDLEN -> (L==0 ? DONE : PRGA) -> DONE -> IDLE.
- NOKEY: writes pt[0]=0x00 in one cycle. No other pt writes occur. Goes to DONE.
- INIT: writes S[i]=i for i=0..255, one per cycle, exactly 256 cycles.
- KSA: j=0. For i=0..255: j=(j+S[i]+keybyte[i mod 3]) mod 256, then swap S[i] and S[j]. At most 6 cycles per i. Must be correct when i==j; the swap is then a no-op.
- RDLEN: reads ct[0] as L (0..255). Writes pt[0]=L.
- PRGA: i=0, j=0. For k=1..L:
  - i=i+1; j=j+S[i]; swap S[i] and S[j].
  - pad=S[(S[i]+S[j]) mod 256].
  - write pt[k]=ct[k]^pad.
  - At most 8 cycles per byte.
- All index arithmetic is 8-bit and wraps mod 256. No overflow flags.
- pt writes occur in strictly ascending address order. pt_wren is a single-cycle pulse per byte. No pt address outside 0..L is ever written.
- Latency bound from the accepting edge to rdy=1: 256 + 256*6 + L*8 + 8 cycles.
- Reset mid-operation (any state): aborts, rdy=1 next cycle, no further writes. A following en restarts from INIT with the newly sampled key.
- key and key_valid may change freely after acceptance.

Decomposition:
- arc4_pkg: state enum (IDLE, NOKEY, INIT, KSA, RDLEN, PRGA, DONE), sub-state enum for the read/compute/swap micro-steps, localparams S_SIZE=256 and KEY_BYTES=3, and a key_byte(key, idx) function.
- One sub-module, s_mem: 256x8 single-port synchronous RAM with 1-cycle read latency, reused by the same FPGA memory flow as ct_mem/pt_mem. The FSM lives in arc4_pt_decrypt.

Test Plan:
- Known vector: key=24'h4B6579 ("Key"), key_valid=1, ct_mem = 09 BB F3 16 E8 D9 40 AF 0A D3 -> pt_mem = 09 50 6C 61 69 6E 74 65 78 74 ("Plaintext"); rdy high within bound; exactly 10 pt writes.
- key_valid=0 with en pulse -> exactly one write, pt[0]=0x00; rdy back to 1 within 3 cycles.
- L=0 (ct[0]=00), key=24'h000018 -> single write pt[0]=00 after INIT+KSA; ct_addr never exceeds 0.
- L=255, key=24'h000018, random ct -> pt matches a bench ARC4 model byte-for-byte; checks i/j wrap and i==j swaps.
- en pulsed while busy, then rst asserted mid-PRGA -> en ignored; rdy=1 and pt_wren=0 the cycle after rst; re-run with key=24'h4B6579 reproduces "Plaintext".
- Back-to-back: en asserted on the first rdy=1 cycle after completion -> accepted; second run's result is correct.
